// File: rtl/obsidian_pkg.sv
// Shared writeback bus field positions, arbiter FSM encoding and the
// multi-cycle result FIFO entry layout.
package obsidian_pkg;
  localparam int WB_REGWRITE = 37;
  localparam int WB_DATA_HI  = 36;
  localparam int WB_DATA_LO  = 5;
  localparam int WB_ADDR_HI  = 4;
  localparam int WB_ADDR_LO  = 0;
  localparam int REG_ADDR_W  = 5;
  localparam int WORD_W      = 32;
  localparam int WB_W        = 38;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_STALL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
  } mc_entry_t;
endpackage

// File: rtl/obsidian_mc_fifo.sv
// Multi-cycle result FIFO with a parallel kill-by-address port that clears
// the live bit of buffered entries overwritten by a younger pipeline write.
module obsidian_mc_fifo
  import obsidian_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [WORD_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_addr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  empty_nxt_o,
  output mc_entry_t             head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] rd_q, rd_d, wr_q, wr_d;
  mc_entry_t   mem_q [DEPTH];
  mc_entry_t   mem_d [DEPTH];

  assign full_o      = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign empty_o     = (rd_q == wr_q);
  assign empty_nxt_o = (rd_d == wr_d);
  assign head_o      = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q + {{AW{1'b0}}, push_i};
    rd_d  = rd_q + {{AW{1'b0}}, pop_i};
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && mem_q[i].addr == kill_addr_i) mem_d[i].live = 1'b0;
    end
    // The written slot is never valid, so it may safely override the kill loop.
    if (push_i) begin
      mem_d[wr_q[AW-1:0]].live = !(kill_i && push_addr_i == kill_addr_i);
      mem_d[wr_q[AW-1:0]].addr = push_addr_i;
      mem_d[wr_q[AW-1:0]].data = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/obsidian_wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback always wins, multi-cycle
// results wait in a FIFO, and a starving FIFO head requests writeback bubbles.
module obsidian_wb_port_arbiter
  import obsidian_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_W-1:0]       wb_id,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_addr,
  input  logic [WORD_W-1:0]     mc_data,
  output logic                  mc_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_W-1:0]     rf_wdata,
  output logic                  pipe_stall
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [WORD_W-1:0]     pipe_data;
  logic                  full, empty, empty_nxt, push, pop, denied;
  mc_entry_t             head;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WORD_W-1:0]     rf_wdata_q, rf_wdata_d;
  arb_state_e            state_q, state_d;
  logic [CW-1:0]         wait_q, wait_d;

  assign pipe_we   = wb_id[WB_REGWRITE];
  assign pipe_addr = wb_id[WB_ADDR_HI:WB_ADDR_LO];
  assign pipe_data = wb_id[WB_DATA_HI:WB_DATA_LO];

  assign mc_ready = !full && !rst;
  assign push     = mc_valid && mc_ready;
  assign pop      = !pipe_we && !empty;
  assign denied   = pipe_we && !empty;

  obsidian_mc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (mc_addr),
    .push_data_i (mc_data),
    .pop_i       (pop),
    .kill_i      (pipe_we),
    .kill_addr_i (pipe_addr),
    .full_o      (full),
    .empty_o     (empty),
    .empty_nxt_o (empty_nxt),
    .head_o      (head)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_we) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      // A killed entry still burns its slot, just without the write strobe.
      rf_we_d    = head.live;
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (denied) wait_d = (wait_q == CW'(STARVE_LIMIT)) ? wait_q : wait_q + 1'b1;
    case (state_q)
      ARB_NORMAL: if (denied && wait_q == CW'(STARVE_LIMIT - 1)) state_d = ARB_STALL;
      ARB_STALL: begin
        if (empty_nxt) begin
          state_d = ARB_NORMAL;
          wait_d  = '0;
        end
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      state_q    <= ARB_NORMAL;
      wait_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      state_q    <= state_d;
      wait_q     <= wait_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = (state_q == ARB_STALL);
endmodule

// File: tb/tb_obsidian_wb_port_arbiter.sv
// Directed vector table for the arbitration corner cases, then randomized
// traffic checked against a queue-based reference model.
module tb_obsidian_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] wb_id = '0;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_addr = '0;
  logic [31:0] mc_data = '0;
  logic        mc_ready, rf_we, pipe_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  obsidian_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .wb_id(wb_id), .mc_valid(mc_valid), .mc_addr(mc_addr),
    .mc_data(mc_data), .mc_ready(mc_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pipe_stall(pipe_stall)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [37:0] wb;
    logic        mcv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
  } vec_t;

  vec_t tv[$];

  function automatic logic [37:0] wbw(input logic [4:0] a, input logic [31:0] d);
    return {1'b1, d, a};
  endfunction

  function automatic void addv(input logic r, input logic [37:0] wb, input logic mcv,
                               input logic [4:0] ma, input logic [31:0] md, input logic rdy,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic st);
    vec_t v;
    v.rst = r; v.wb = wb; v.mcv = mcv; v.ma = ma; v.md = md;
    v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.st = st;
    tv.push_back(v);
  endfunction

  typedef struct {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  ment_t       h;
  logic        m_we, m_st, was_empty, acc, r_rst, r_mcv;
  logic [4:0]  m_wa, r_ma;
  logic [31:0] m_wd, r_md;
  logic [37:0] r_wb;
  int          deny, pp;

  initial begin
    // rst wb mcv ma md | rdy we wa wd st
    addv(1'b1, '0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    addv(1'b0, wbw(5'd7, 32'hDEADBEEF), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    addv(1'b0, '0, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h12345678, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hA0000001), 1'b1, 5'd10, 32'hD0000010, 1'b1, 1'b1, 5'd1, 32'hA0000001, 1'b0);
    addv(1'b0, wbw(5'd2, 32'hA0000002), 1'b1, 5'd11, 32'hD0000011, 1'b1, 1'b1, 5'd2, 32'hA0000002, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hA0000003), 1'b1, 5'd12, 32'hD0000012, 1'b0, 1'b1, 5'd1, 32'hA0000003, 1'b0);
    addv(1'b0, wbw(5'd2, 32'hA0000004), 1'b1, 5'd12, 32'hD0000012, 1'b0, 1'b1, 5'd2, 32'hA0000004, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hA0000005), 1'b1, 5'd12, 32'hD0000012, 1'b0, 1'b1, 5'd1, 32'hA0000005, 1'b1);
    addv(1'b0, '0, 1'b1, 5'd12, 32'hD0000012, 1'b0, 1'b1, 5'd10, 32'hD0000010, 1'b1);
    addv(1'b0, '0, 1'b1, 5'd12, 32'hD0000012, 1'b1, 1'b1, 5'd11, 32'hD0000011, 1'b1);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd12, 32'hD0000012, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd12, 32'hD0000012, 1'b0);
    addv(1'b0, '0, 1'b1, 5'd9, 32'hD0000009, 1'b1, 1'b0, 5'd12, 32'hD0000012, 1'b0);
    addv(1'b0, wbw(5'd9, 32'hB0000009), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 32'hB0000009, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'hD0000009, 1'b0);
    addv(1'b0, wbw(5'd5, 32'hC0000005), 1'b1, 5'd5, 32'hD0000005, 1'b1, 1'b1, 5'd5, 32'hC0000005, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'hD0000005, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hE0000001), 1'b1, 5'd20, 32'hD0000020, 1'b1, 1'b1, 5'd1, 32'hE0000001, 1'b0);
    addv(1'b0, wbw(5'd2, 32'hE0000002), 1'b1, 5'd21, 32'hD0000021, 1'b1, 1'b1, 5'd2, 32'hE0000002, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hE0000003), 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd1, 32'hE0000003, 1'b0);
    addv(1'b0, wbw(5'd2, 32'hE0000004), 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd2, 32'hE0000004, 1'b0);
    addv(1'b0, wbw(5'd1, 32'hE0000005), 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd1, 32'hE0000005, 1'b1);
    addv(1'b1, '0, 1'b1, 5'd22, 32'hD0000022, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    addv(1'b0, '0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

    @(negedge clk);
    foreach (tv[i]) begin
      rst = tv[i].rst; wb_id = tv[i].wb; mc_valid = tv[i].mcv;
      mc_addr = tv[i].ma; mc_data = tv[i].md;
      #1 chk($sformatf("v%0d.mc_ready", i), 32'(mc_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.rf_we", i), 32'(rf_we), 32'(tv[i].we));
      chk($sformatf("v%0d.rf_waddr", i), 32'(rf_waddr), 32'(tv[i].wa));
      chk($sformatf("v%0d.rf_wdata", i), rf_wdata, tv[i].wd);
      chk($sformatf("v%0d.pipe_stall", i), 32'(pipe_stall), 32'(tv[i].st));
      @(negedge clk);
    end

    m_we = 1'b0; m_wa = '0; m_wd = '0; m_st = 1'b0; deny = 0; pp = 50;
    for (int c = 0; c < 500; c++) begin
      if (c % 16 == 0) pp = (c % 48 == 0) ? 20 : ((c % 48 == 16) ? 80 : 100);
      r_rst = (c == 0) || ($urandom_range(0, 59) == 0);
      r_wb  = {($urandom_range(0, 99) < pp), 32'($urandom), 5'($urandom_range(0, 3))};
      r_mcv = ($urandom_range(0, 99) < 60);
      r_ma  = 5'($urandom_range(0, 3));
      r_md  = 32'($urandom);
      rst = r_rst; wb_id = r_wb; mc_valid = r_mcv; mc_addr = r_ma; mc_data = r_md;
      #1 chk("rnd.mc_ready", 32'(mc_ready), 32'(!r_rst && q.size() < DEPTH));

      if (r_rst) begin
        q.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_st = 1'b0; deny = 0;
      end else begin
        was_empty = (q.size() == 0);
        acc = r_mcv && (q.size() < DEPTH);
        if (r_wb[37]) begin
          foreach (q[k]) if (q[k].addr == r_wb[4:0]) q[k].live = 1'b0;
          m_we = 1'b1; m_wa = r_wb[4:0]; m_wd = r_wb[36:5];
        end else if (!was_empty) begin
          h = q.pop_front();
          m_we = h.live; m_wa = h.addr; m_wd = h.data;
        end else begin
          m_we = 1'b0;
        end
        if (acc) begin
          h.live = !(r_wb[37] && r_ma == r_wb[4:0]); h.addr = r_ma; h.data = r_md;
          q.push_back(h);
        end
        if (m_st) begin
          if (q.size() == 0) begin m_st = 1'b0; deny = 0; end
        end else if (!was_empty && r_wb[37]) begin
          deny++;
          if (deny >= LIM) m_st = 1'b1;
        end else begin
          deny = 0;
        end
      end

      @(posedge clk);
      #1;
      chk("rnd.rf_we", 32'(rf_we), 32'(m_we));
      chk("rnd.rf_waddr", 32'(rf_waddr), 32'(m_wa));
      chk("rnd.rf_wdata", rf_wdata, m_wd);
      chk("rnd.pipe_stall", 32'(pipe_stall), 32'(m_st));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
